// File: rtl/regfile_if.sv
// Register-file access bundle: one write port and two read ports.
// The master drives addresses and write data; the slave returns read data.
interface regfile_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [WIDTH-1:0]  rd_data0;
    logic [WIDTH-1:0]  rd_data1;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr0, rd_addr1,
        output rd_data0, rd_data1
    );
endinterface

// File: rtl/regfile.sv
// MIPS general-purpose register file: two combinational read ports, one clocked write port, $0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             fwd0_c;
    logic             fwd1_c;

    // Reset wins over a coincident write; writes to entry 0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic write_hit_c;
    assign write_hit_c = !reset && bus.wr_en && (bus.wr_addr != '0);
    assign fwd0_c      = write_hit_c && (bus.rd_addr0 == bus.wr_addr);
    assign fwd1_c      = write_hit_c && (bus.rd_addr1 == bus.wr_addr);
`else
    assign fwd0_c = 1'b0;
    assign fwd1_c = 1'b0;
`endif

    // Entry 0 is forced to zero on read so it is defined even before the first reset.
    always_comb begin
        bus.rd_data0 = '0;
        if (fwd0_c) begin
            bus.rd_data0 = bus.wr_data;
        end else if (bus.rd_addr0 != '0) begin
            bus.rd_data0 = mem[bus.rd_addr0];
        end
    end

    always_comb begin
        bus.rd_data1 = '0;
        if (fwd1_c) begin
            bus.rd_data1 = bus.wr_data;
        end else if (bus.rd_addr1 != '0) begin
            bus.rd_data1 = mem[bus.rd_addr1];
        end
    end
endmodule
